// File: rtl/key_encoder_pkg.sv
// key_encoder_pkg: shared constants and index helpers for the key encoder.
//   MODE_HIGH / MODE_LOW / MODE_LAST : priority modes for the level output.
//   MAX_KEYS                         : widest key vector the helpers accept.
//   hi_idx / lo_idx                  : highest / lowest set bit index (0 when empty).
package key_encoder_pkg;

  localparam int MODE_HIGH = 0;
  localparam int MODE_LOW  = 1;
  localparam int MODE_LAST = 2;

  localparam int MAX_KEYS  = 64;

  function automatic int hi_idx(input logic [MAX_KEYS-1:0] v);
    int r;
    r = 0;
    for (int i = 0; i < MAX_KEYS; i++) begin
      if (v[i]) r = i;
    end
    return r;
  endfunction

  function automatic int lo_idx(input logic [MAX_KEYS-1:0] v);
    int r;
    r = 0;
    for (int i = MAX_KEYS - 1; i >= 0; i--) begin
      if (v[i]) r = i;
    end
    return r;
  endfunction

endpackage

// File: rtl/key_encoder_debounce.sv
// key_debounce: per-key 2-flop synchroniser plus debounce counter.
//   clk_i    : system clock
//   rst_n_i  : synchronous active-low reset
//   sw_i     : raw asynchronous key level
//   stable_o : debounced key level
//   toggle_o : high in the cycle stable_o is about to flip
module key_debounce #(
  parameter  int DEBOUNCE_CYCLES = 1000,
  localparam int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic sw_i,
  output logic stable_o,
  output logic toggle_o
);

  logic             sync_p0;
  logic             sync_q;
  logic [CNT_W-1:0] cnt;
  logic             differ;

  assign differ   = (sync_q != stable_o);
  // The final mismatching sample flips stable_o instead of incrementing.
  assign toggle_o = differ && (cnt == CNT_W'(DEBOUNCE_CYCLES - 1));

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      sync_p0  <= 1'b0;
      sync_q   <= 1'b0;
      cnt      <= '0;
      stable_o <= 1'b0;
    end else begin
      // stage: synchroniser
      sync_p0 <= sw_i;
      sync_q  <= sync_p0;
      // stage: debounce
      if (!differ || toggle_o) cnt <= '0;
      else                     cnt <= cnt + 1'b1;
      if (toggle_o) stable_o <= ~stable_o;
    end
  end

endmodule

// File: rtl/key_encoder.sv
// key_encoder: debounced N-key encoder with level output and event FIFO.
//   clk_i, rst_n_i       : clock, synchronous active-low reset
//   sw_i                 : raw key levels, 1 = pressed
//   num_o, num_val_o     : selected key index / at least one key held
//   ev_val_o, ev_ready_i : event FIFO head valid / consumer accepts head
//   ev_num_o, ev_on_o    : head event key index / 1 = press, 0 = release
module key_encoder
  import key_encoder_pkg::*;
#(
  parameter  int KEYS            = 8,
  parameter  int DEBOUNCE_CYCLES = 1000,
  parameter  int MODE            = 0,
  parameter  int EV_DEPTH        = 4,
  localparam int NUM_W           = $clog2(KEYS)
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [KEYS-1:0]  sw_i,
  output logic [NUM_W-1:0] num_o,
  output logic             num_val_o,
  output logic             ev_val_o,
  input  logic             ev_ready_i,
  output logic [NUM_W-1:0] ev_num_o,
  output logic             ev_on_o
);

  typedef struct packed {
    logic             on;
    logic [NUM_W-1:0] num;
  } key_ev_t;

  localparam int PTR_W = $clog2(EV_DEPTH);

  logic [KEYS-1:0]     stable;
  logic [KEYS-1:0]     tgl;
  logic [KEYS-1:0]     stable_p1;
  logic [MAX_KEYS-1:0] stable_ext;
  logic [MAX_KEYS-1:0] rise_ext;
  logic [NUM_W-1:0]    hi_sel;
  logic [NUM_W-1:0]    lo_sel;
  logic [NUM_W-1:0]    last_sel;
  logic [NUM_W-1:0]    num_sel;
  logic [NUM_W-1:0]    last_r;

  logic [KEYS-1:0]     pend;
  logic [KEYS-1:0]     push_mask;
  logic [MAX_KEYS-1:0] pend_ext;
  logic [NUM_W-1:0]    scan_num;
  key_ev_t             push_ev;
  key_ev_t             head;
  logic                push;
  logic                pop;
  logic                full;
  logic                empty;
  logic [PTR_W:0]      wr_ptr;
  logic [PTR_W:0]      rd_ptr;
  key_ev_t             mem [EV_DEPTH];

  // stage: synchronise + debounce, one instance per key
  for (genvar k = 0; k < KEYS; k++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .sw_i    (sw_i[k]),
      .stable_o(stable[k]),
      .toggle_o(tgl[k])
    );
  end

  // stage: level output selection
  assign stable_ext = MAX_KEYS'(stable);
  assign rise_ext   = MAX_KEYS'(stable & ~stable_p1);

  always_comb begin
    hi_sel = NUM_W'(hi_idx(stable_ext));
    lo_sel = NUM_W'(lo_idx(stable_ext));
    // A fresh press takes over; otherwise keep the remembered key while it
    // is still held, falling back to the highest held key.
    if (|rise_ext)           last_sel = NUM_W'(hi_idx(rise_ext));
    else if (stable[last_r]) last_sel = last_r;
    else                     last_sel = hi_sel;
    case (MODE)
      MODE_LOW:  num_sel = lo_sel;
      MODE_LAST: num_sel = last_sel;
      default:   num_sel = hi_sel;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      stable_p1 <= '0;
      num_o     <= '0;
      num_val_o <= 1'b0;
      last_r    <= '0;
    end else begin
      stable_p1 <= stable;
      num_val_o <= |stable;
      if (|stable) begin
        num_o  <= num_sel;
        last_r <= last_sel;
      end
    end
  end

  // stage: pending mask and event scanner
  assign pend_ext = MAX_KEYS'(pend);
  assign scan_num = NUM_W'(lo_idx(pend_ext));
  assign pop      = !empty && ev_ready_i;
  assign push     = (|pend) && (!full || pop);

  always_comb begin
    push_mask = '0;
    if (push) push_mask[scan_num] = 1'b1;
    push_ev.on  = stable[scan_num];
    push_ev.num = scan_num;
  end

  // XOR with the toggle: a second change while pending cancels the first,
  // and a change in the cycle the bit is pushed re-arms it.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) pend <= '0;
    else          pend <= (pend & ~push_mask) ^ tgl;
  end

  // stage: event FIFO (show-ahead)
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                 (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr[PTR_W-1:0]] <= push_ev;
  end

  // Head fields are forced to 0 while empty so they read as cleared after reset.
  assign head     = mem[rd_ptr[PTR_W-1:0]];
  assign ev_val_o = !empty;
  assign ev_num_o = empty ? '0 : head.num;
  assign ev_on_o  = !empty && head.on;

endmodule

// File: tb/tb_key_encoder.sv
// tb_key_encoder: directed bench for key_encoder with one DUT per priority
// mode sharing the same stimulus, checked against a behavioural model.
module tb_key_encoder;

  localparam int KEYS  = 8;
  localparam int D     = 4;
  localparam int DEPTH = 4;
  localparam int NW    = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    sw = '0;
  logic          ev_ready = 1'b0;
  logic [NW-1:0] num_a [3];
  logic [NW-1:0] ev_num_a [3];
  logic          num_val_a [3];
  logic          ev_val_a [3];
  logic          ev_on_a [3];

  always #5 clk = ~clk;

  for (genvar m = 0; m < 3; m++) begin : g_dut
    key_encoder #(
      .KEYS(KEYS), .DEBOUNCE_CYCLES(D), .MODE(m), .EV_DEPTH(DEPTH)
    ) u_dut (
      .clk_i     (clk),
      .rst_n_i   (rst_n),
      .sw_i      (sw),
      .num_o     (num_a[m]),
      .num_val_o (num_val_a[m]),
      .ev_val_o  (ev_val_a[m]),
      .ev_ready_i(ev_ready),
      .ev_num_o  (ev_num_a[m]),
      .ev_on_o   (ev_on_a[m])
    );
  end

  int n_vec  = 0;
  int n_fail = 0;
  int cyc    = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int f_hi(input logic [7:0] v);
    int r = 0;
    for (int i = 0; i < 8; i++) if (v[i]) r = i;
    return r;
  endfunction

  function automatic int f_lo(input logic [7:0] v);
    int r = 0;
    for (int i = 7; i >= 0; i--) if (v[i]) r = i;
    return r;
  endfunction

  // Model: a key's accepted level flips once its synchronised samples
  // have disagreed with it for D consecutive cycles.
  logic [7:0] m_st, m_st_prev, m_sd1, m_sd2, m_rise;
  logic [7:0] m_win [D];
  int         m_num [3];
  bit         m_val;
  int         m_last;
  bit         m_ad;

  task automatic model_step();
    if (!rst_n) begin
      m_st = '0; m_st_prev = '0; m_sd1 = '0; m_sd2 = '0;
      for (int i = 0; i < D; i++) m_win[i] = '0;
      for (int i = 0; i < 3; i++) m_num[i] = 0;
      m_val = 1'b0; m_last = 0;
    end else begin
      m_val = |m_st;
      if (|m_st) begin
        m_rise = m_st & ~m_st_prev;
        if (m_rise != 0)       m_last = f_hi(m_rise);
        else if (!m_st[m_last]) m_last = f_hi(m_st);
        m_num[0] = f_hi(m_st);
        m_num[1] = f_lo(m_st);
        m_num[2] = m_last;
      end
      m_st_prev = m_st;
      for (int i = D - 1; i > 0; i--) m_win[i] = m_win[i-1];
      m_win[0] = m_sd2;
      for (int k = 0; k < 8; k++) begin
        m_ad = 1'b1;
        for (int j = 0; j < D; j++) if (m_win[j][k] == m_st[k]) m_ad = 1'b0;
        if (m_ad) m_st[k] = ~m_st[k];
      end
      m_sd2 = m_sd1;
      m_sd1 = sw;
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
    model_step();
  end

  // Delivered events: per key, each event must report the opposite of the
  // last reported level. DUT 0's stream is logged for ordering checks.
  bit rep [3][8];
  int ev_log[$];
  int ev_cyc[$];

  task automatic cmp_step();
    if (!rst_n) begin
      for (int m = 0; m < 3; m++) for (int k = 0; k < 8; k++) rep[m][k] = 1'b0;
    end
    if (chk_en) begin
      for (int m = 0; m < 3; m++) begin
        chk($sformatf("num_o[mode%0d]", m), int'(num_a[m]), m_num[m]);
        chk($sformatf("num_val_o[mode%0d]", m), int'(num_val_a[m]), int'(m_val));
      end
    end
    if (rst_n) begin
      for (int m = 0; m < 3; m++) begin
        if (ev_val_a[m] && ev_ready) begin
          chk($sformatf("ev_on alternation[mode%0d key%0d]", m, ev_num_a[m]),
              int'(ev_on_a[m]), int'(!rep[m][ev_num_a[m]]));
          rep[m][ev_num_a[m]] = ev_on_a[m];
          if (m == 0) begin
            ev_log.push_back(int'(ev_on_a[0]) * 100 + int'(ev_num_a[0]));
            ev_cyc.push_back(cyc);
          end
        end
      end
    end
  endtask

  initial forever begin
    @(negedge clk);
    cmp_step();
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_log(input string name, input int exp[$]);
    chk({name, " count"}, ev_log.size(), exp.size());
    for (int i = 0; i < exp.size(); i++) begin
      if (i < ev_log.size()) chk($sformatf("%s[%0d]", name, i), ev_log[i], exp[i]);
    end
  endtask

  initial begin
    // Reset with every key pressed: all outputs cleared.
    rst_n = 1'b0; sw = 8'hFF; ev_ready = 1'b0;
    repeat (3) tick();
    for (int m = 0; m < 3; m++) begin
      chk("reset num_o", int'(num_a[m]), 0);
      chk("reset num_val_o", int'(num_val_a[m]), 0);
      chk("reset ev_val_o", int'(ev_val_a[m]), 0);
      chk("reset ev_num_o", int'(ev_num_a[m]), 0);
      chk("reset ev_on_o", int'(ev_on_a[m]), 0);
    end
    sw = 8'h00;
    repeat (2) tick();
    rst_n = 1'b1; chk_en = 1'b1;
    repeat (2) tick();

    // Press key 3: level output exactly 2 + D + 1 cycles after the edge.
    sw = 8'h08;
    repeat (2 + D) tick();
    chk("latency num_val_o early", int'(num_val_a[0]), 0);
    tick();
    chk("latency num_val_o", int'(num_val_a[0]), 1);
    chk("latency num_o", int'(num_a[0]), 3);
    chk("first ev_val_o", int'(ev_val_a[0]), 1);
    chk("first ev_num_o", int'(ev_num_a[0]), 3);
    chk("first ev_on_o", int'(ev_on_a[0]), 1);
    repeat (3) tick();
    chk("stalled ev_num_o", int'(ev_num_a[0]), 3);
    chk("stalled ev_on_o", int'(ev_on_a[0]), 1);
    ev_ready = 1'b1;
    sw = 8'h00;
    repeat (12) tick();
    chk_log("key3 events", '{103, 3});

    // Glitch one cycle shorter than the debounce window.
    ev_log.delete(); ev_cyc.delete();
    sw = 8'h20;
    repeat (D - 1) tick();
    sw = 8'h00;
    repeat (12) tick();
    chk("glitch events", ev_log.size(), 0);
    chk("glitch num_val_o", int'(num_val_a[0]), 0);

    // Priority modes: press 1, then 6, then 4.
    ev_log.delete(); ev_cyc.delete();
    sw = 8'h02; repeat (8) tick();
    sw = 8'h42; repeat (8) tick();
    sw = 8'h52; repeat (8) tick();
    chk("mode high num_o", int'(num_a[0]), 6);
    chk("mode low num_o", int'(num_a[1]), 1);
    chk("mode last num_o", int'(num_a[2]), 4);
    sw = 8'h42; repeat (8) tick();
    chk("mode last after release num_o", int'(num_a[2]), 6);
    chk("mode low after release num_o", int'(num_a[1]), 1);
    sw = 8'h00; repeat (10) tick();
    chk_log("priority events", '{101, 106, 104, 4, 1, 6});
    chk("num_o holds with no keys", int'(num_a[2]), 6);

    // Simultaneous presses of keys 0, 2, 7.
    ev_log.delete(); ev_cyc.delete();
    sw = 8'h85; repeat (10) tick();
    chk_log("simultaneous on", '{100, 102, 107});
    if (ev_cyc.size() == 3) begin
      chk("simultaneous spacing 0-2", ev_cyc[1] - ev_cyc[0], 1);
      chk("simultaneous spacing 2-7", ev_cyc[2] - ev_cyc[1], 1);
    end
    sw = 8'h00; repeat (10) tick();
    chk_log("simultaneous all", '{100, 102, 107, 0, 2, 7});

    // Back-pressure: 6 events against a 4-deep FIFO.
    ev_log.delete(); ev_cyc.delete();
    ev_ready = 1'b0;
    sw = 8'h0E; repeat (8) tick();
    sw = 8'h00; repeat (12) tick();
    chk("bp ev_val_o", int'(ev_val_a[0]), 1);
    chk("bp head num", int'(ev_num_a[0]), 1);
    chk("bp head on", int'(ev_on_a[0]), 1);
    repeat (3) tick();
    chk("bp head num held", int'(ev_num_a[0]), 1);
    chk("bp head on held", int'(ev_on_a[0]), 1);
    chk("bp nothing delivered", ev_log.size(), 0);
    ev_ready = 1'b1;
    repeat (12) tick();
    chk_log("bp events", '{101, 102, 103, 1, 2, 3});
    chk("bp drained ev_val_o", int'(ev_val_a[0]), 0);

    // Reset with two events queued.
    ev_log.delete(); ev_cyc.delete();
    ev_ready = 1'b0;
    sw = 8'h11; repeat (10) tick();
    chk("pre-reset ev_val_o", int'(ev_val_a[0]), 1);
    sw = 8'h00; rst_n = 1'b0;
    tick();
    for (int m = 0; m < 3; m++) begin
      chk("mid reset ev_val_o", int'(ev_val_a[m]), 0);
      chk("mid reset num_val_o", int'(num_val_a[m]), 0);
    end
    tick();
    rst_n = 1'b1; ev_ready = 1'b1;
    repeat (20) tick();
    chk("post reset stale events", ev_log.size(), 0);
    chk("post reset ev_val_o", int'(ev_val_a[0]), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
